// File: rtl/vd_ber_checker.sv
// Bit-error-rate checker for the Viterbi decoder output stream.
// Hunts for decoder latency over a source-bit history, then counts bits and errors.
module vd_ber_checker #(
  parameter int MAX_LAT  = 64,
  parameter int W_OFS    = 6,
  parameter int SYNC_WIN = 16,
  parameter int SYNC_THR = 1,
  parameter int LOSS_WIN = 32,
  parameter int LOSS_THR = 8,
  parameter int W_CNT    = 16
) (
  input  logic             CLOCK,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             SrcStrobe,
  input  logic             SrcBit,
  input  logic             DecStrobe,
  input  logic             DecBit,
  output logic             Locked,
  output logic [W_OFS-1:0] Offset,
  output logic [W_CNT-1:0] BitCount,
  output logic [W_CNT-1:0] ErrCount,
  output logic             ErrPulse
);

  localparam int WMAX  = (SYNC_WIN > LOSS_WIN) ? SYNC_WIN : LOSS_WIN;
  localparam int W_WIN = $clog2(WMAX + 1);

  localparam logic [W_OFS-1:0] OFS_LAST = W_OFS'(MAX_LAT - 1);
  localparam logic [W_CNT-1:0] CNT_MAX  = '1;
  localparam logic [W_WIN-1:0] SYNC_W   = W_WIN'(SYNC_WIN);
  localparam logic [W_WIN-1:0] SYNC_T   = W_WIN'(SYNC_THR);
  localparam logic [W_WIN-1:0] LOSS_W   = W_WIN'(LOSS_WIN);
  localparam logic [W_WIN-1:0] LOSS_T   = W_WIN'(LOSS_THR);

  typedef enum logic {
    HUNT,
    LOCK
  } state_t;

  state_t             state;
  logic [MAX_LAT-1:0] hist;
  logic [W_WIN-1:0]   win_cnt;
  logic [W_WIN-1:0]   win_err;
  logic               mismatch;
  logic [W_WIN-1:0]   cnt_nxt;
  logic [W_WIN-1:0]   err_nxt;

  // Compare against the pre-shift history so a coincident source bit is not seen.
  always_comb begin
    mismatch = DecBit ^ hist[Offset];
    cnt_nxt  = win_cnt + 1'b1;
    err_nxt  = win_err + W_WIN'(mismatch);
  end

  always_ff @(posedge CLOCK) begin
    if (Reset) begin
      state    <= HUNT;
      hist     <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      Locked   <= 1'b0;
      Offset   <= '0;
      BitCount <= '0;
      ErrCount <= '0;
      ErrPulse <= 1'b0;
    end else begin
      ErrPulse <= 1'b0;
      if (SrcStrobe)
        hist <= {hist[MAX_LAT-2:0], SrcBit};
      if (DecStrobe) begin
        unique case (state)
          HUNT: begin
            if (cnt_nxt == SYNC_W) begin
              win_cnt <= '0;
              win_err <= '0;
              if (err_nxt <= SYNC_T) begin
                state  <= LOCK;
                Locked <= 1'b1;
              end else begin
                Offset <= (Offset == OFS_LAST) ? '0 : Offset + 1'b1;
              end
            end else begin
              win_cnt <= cnt_nxt;
              win_err <= err_nxt;
            end
          end
          LOCK: begin
            if (!Clear) begin
              if (BitCount != CNT_MAX)
                BitCount <= BitCount + 1'b1;
              if (mismatch) begin
                ErrPulse <= 1'b1;
                if (ErrCount != CNT_MAX)
                  ErrCount <= ErrCount + 1'b1;
              end
            end
            if (cnt_nxt == LOSS_W) begin
              win_cnt <= '0;
              win_err <= '0;
              if (err_nxt > LOSS_T) begin
                state  <= HUNT;
                Locked <= 1'b0;
                Offset <= '0;
              end
            end else begin
              win_cnt <= cnt_nxt;
              win_err <= err_nxt;
            end
          end
        endcase
      end
      if (Clear) begin
        BitCount <= '0;
        ErrCount <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vd_ber_checker.sv
// Scoreboard bench for vd_ber_checker: directed streams with
// hand-computed lock points, counts and error-pulse cycles.
module tb_vd_ber_checker;

  logic        CLOCK = 1'b0;
  logic        Reset = 1'b1;
  logic        Clear = 1'b0;
  logic        SrcStrobe = 1'b0;
  logic        SrcBit = 1'b0;
  logic        DecStrobe = 1'b0;
  logic        DecBit = 1'b0;
  logic        Locked;
  logic [5:0]  Offset;
  logic [15:0] BitCount;
  logic [15:0] ErrCount;
  logic        ErrPulse;

  typedef struct packed {
    logic        lk;
    logic [5:0]  ofs;
    logic [15:0] bc;
    logic [15:0] ec;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    pulse_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  logic  chk_req = 1'b0;
  logic  no_lock = 1'b0;
  logic  saw_lock = 1'b0;

  vd_ber_checker dut (
    .CLOCK(CLOCK),
    .Reset(Reset),
    .Clear(Clear),
    .SrcStrobe(SrcStrobe),
    .SrcBit(SrcBit),
    .DecStrobe(DecStrobe),
    .DecBit(DecBit),
    .Locked(Locked),
    .Offset(Offset),
    .BitCount(BitCount),
    .ErrCount(ErrCount),
    .ErrPulse(ErrPulse)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Monitor: pops checkpoints and expected pulse cycles.
  always @(negedge CLOCK) begin
    exp_t  e;
    string nm;
    int    w;
    if (chk_req) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: checkpoint with empty queue");
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({Locked, Offset, BitCount, ErrCount} !== e) begin
          errors++;
          $display("FAIL %s: got lk=%0d ofs=%0d bc=%0d ec=%0d want lk=%0d ofs=%0d bc=%0d ec=%0d",
                   nm, Locked, Offset, BitCount, ErrCount,
                   e.lk, e.ofs, e.bc, e.ec);
        end
      end
    end
    if (ErrPulse === 1'b1) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL err_pulse: unexpected pulse at cycle %0d, want none", cyc);
      end else begin
        w = pulse_q.pop_front();
        if (w != cyc) begin
          errors++;
          $display("FAIL err_pulse: pulse at cycle %0d, want cycle %0d", cyc, w);
        end
      end
    end
    if (no_lock && Locked !== 1'b0)
      saw_lock <= 1'b1;
  end

  // Source pattern: a one every 6th bit, zero before the stream starts.
  function automatic logic s(input int n);
    return (n >= 0) && (n % 6 == 0);
  endfunction

  task automatic tick(input logic ss, input logic sb, input logic ds,
                      input logic db, input logic cl);
    SrcStrobe = ss;
    SrcBit    = sb;
    DecStrobe = ds;
    DecBit    = db;
    Clear     = cl;
    @(posedge CLOCK);
    #1;
    SrcStrobe = 1'b0;
    DecStrobe = 1'b0;
    Clear     = 1'b0;
  endtask

  // Source bit n, then decoded bit for source n-5 (latency 5).
  task automatic bit_step(input int n, input logic inv,
                          input logic pulse, input logic clr);
    tick(1'b1, s(n), 1'b0, 1'b0, 1'b0);
    if (pulse)
      pulse_q.push_back(cyc + 1);
    tick(1'b0, 1'b0, 1'b1, s(n - 5) ^ inv, clr);
  endtask

  task automatic chk(input string nm, input logic lk, input int ofs,
                     input int bc, input int ec);
    exp_t e;
    e.lk  = lk;
    e.ofs = 6'(ofs);
    e.bc  = 16'(bc);
    e.ec  = 16'(ec);
    exp_q.push_back(e);
    name_q.push_back(nm);
    chk_req = 1'b1;
    @(posedge CLOCK);
    #1;
    chk_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic inv;
    Reset = 1'b1;
    repeat (3) @(posedge CLOCK);
    #1;
    Reset = 1'b0;
    chk("reset", 1'b0, 0, 0, 0);

    // Hunt from offset 0, lock at offset 5 on decoded bit 96.
    for (int n = 0; n < 200; n++) begin
      bit_step(n, 1'b0, 1'b0, 1'b0);
      if (n == 15) chk("hunt_ofs1", 1'b0, 1, 0, 0);
      if (n == 94) chk("pre_lock", 1'b0, 5, 0, 0);
      if (n == 95) chk("lock", 1'b1, 5, 0, 0);
    end
    chk("lock_count", 1'b1, 5, 104, 0);

    // Three isolated errors while locked.
    for (int n = 200; n < 300; n++) begin
      inv = (n == 210) || (n == 230) || (n == 250);
      bit_step(n, inv, inv, 1'b0);
    end
    chk("three_err", 1'b1, 5, 204, 3);

    // Window 320..351 gets 11 errors: lock is lost at its end.
    for (int n = 300; n < 352; n++) begin
      inv = (n >= 320) && ((n - 320) % 3 == 0);
      bit_step(n, inv, inv, 1'b0);
      if (n == 350) chk("pre_loss", 1'b1, 5, 255, 14);
    end
    chk("loss", 1'b0, 0, 256, 14);

    // Clean stream again: relock at offset 5 after six hunt windows.
    for (int n = 352; n < 448; n++) begin
      bit_step(n, 1'b0, 1'b0, 1'b0);
      if (n == 446) chk("relock_pre", 1'b0, 5, 256, 14);
    end
    chk("relock", 1'b1, 5, 256, 14);

    // Clear with an erroring strobe: nothing counted, no pulse.
    bit_step(448, 1'b1, 1'b0, 1'b1);
    chk("clear", 1'b1, 5, 0, 0);
    bit_step(449, 1'b1, 1'b1, 1'b0);
    chk("after_clear", 1'b1, 5, 1, 1);

    // Reset while locked, with an erroring strobe in the same cycle.
    Reset = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    Reset = 1'b0;
    chk("mid_reset", 1'b0, 0, 0, 0);

    // Coincident strobes every cycle: pre-shift compare means lag 6 -> offset 5.
    for (int m = 0; m < 200; m++) begin
      tick(1'b1, s(m), 1'b1, s(m - 6), 1'b0);
      if (m == 94) chk("conc_pre", 1'b0, 5, 0, 0);
      if (m == 95) chk("conc_lock", 1'b1, 5, 0, 0);
    end
    chk("concurrent", 1'b1, 5, 104, 0);

    // Empty history, alternating DecBit: 8 errors per window, never locks.
    Reset = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    no_lock = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tick(1'b0, 1'b0, 1'b1, (i % 2) == 0, 1'b0);
      if (i == 1007) chk("wrap63", 1'b0, 63, 0, 0);
    end
    chk("wrap0", 1'b0, 0, 0, 0);
    no_lock = 1'b0;
    @(posedge CLOCK);
    #1;

    checks++;
    if (saw_lock) begin
      errors++;
      $display("FAIL no_lock: Locked=1 seen during uncorrelated stream, want 0");
    end
    checks++;
    if (pulse_q.size() != 0) begin
      errors++;
      $display("FAIL pulse_count: %0d expected pulses missing, want 0", pulse_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
